// File: rtl/mem_loader_pkg.sv
// ============================================================================
// Module      : mem_loader_pkg
// Description : Shared types and constants for the memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_HDR0  = 4'd1,
        ST_HDR1  = 4'd2,
        ST_HDR2  = 4'd3,
        ST_HDR3  = 4'd4,
        ST_DATA  = 4'd5,
        ST_SETUP = 4'd6,
        ST_PULSE = 4'd7,
        ST_HOLDW = 4'd8,
        ST_CSUM  = 4'd9,
        ST_DONE  = 4'd10,
        ST_RUN   = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_PULSE = 2'd2,
        PH_HOLD  = 2'd3
    } phase_t;

    localparam int HDR_LEN    = 4;
    localparam int CSUM_WIDTH = 8;

    // Bits needed to count down from the longest of the three strobe phases.
    function automatic int cycle_cnt_width(input int s, input int p, input int h);
        int m;
        m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_write_strobe.sv
// ============================================================================
// Module      : mem_write_strobe
// Description : Sequences setup / pulse / hold phases of one write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_write_strobe
    import mem_loader_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_go,
    output logic o_we_bar,
    output logic o_phase_end,
    output logic o_done
);

    localparam int CNT_W = cycle_cnt_width(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES);

    localparam logic [CNT_W-1:0] c_setup_ld = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pulse_ld = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_ld  = CNT_W'(HOLD_CYCLES - 1);

    phase_t           r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we_bar;
    logic             w_last;

    assign w_last = (r_phase != PH_IDLE) && (r_cnt == '0);

    // The strobe itself is registered so it never glitches on the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= PH_IDLE;
            r_cnt    <= '0;
            r_we_bar <= 1'b1;
        end else begin
            case (r_phase)
                PH_IDLE: begin
                    if (i_go) begin
                        r_phase <= PH_SETUP;
                        r_cnt   <= c_setup_ld;
                    end
                end
                PH_SETUP: begin
                    if (w_last) begin
                        r_phase  <= PH_PULSE;
                        r_cnt    <= c_pulse_ld;
                        r_we_bar <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PH_PULSE: begin
                    if (w_last) begin
                        r_phase  <= PH_HOLD;
                        r_cnt    <= c_hold_ld;
                        r_we_bar <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                PH_HOLD: begin
                    if (w_last) begin
                        r_phase <= PH_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_phase  <= PH_IDLE;
                    r_we_bar <= 1'b1;
                end
            endcase
        end
    end

    assign o_we_bar    = r_we_bar;
    assign o_phase_end = w_last;
    assign o_done      = w_last && (r_phase == PH_HOLD);

endmodule

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// Module      : mem_loader
// Description : Loads a framed byte stream into program RAM while holding the
//               CPU in reset. Optional trailing checksum: MEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [7:0]            IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [7:0]            MEM_DATA,
    output logic                  MEM_WE_bar,
    output logic                  MEM_DRIVE,
    output logic                  CPU_RST_bar,
    output logic                  BUSY,
    output logic                  ERR
);

    state_t                r_state;
    logic                  r_in_ready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_data;
    logic [7:0]            r_byte_hi;
    logic [15:0]           r_remaining;
    logic                  r_drive;
    logic                  r_busy;
    logic                  r_cpu_rst_n;

    logic w_accept;
    logic w_go;
    logic w_phase_end;
    logic w_done;
    logic w_last_byte;

`ifdef MEM_LOADER_CHECKSUM_EN
    logic                  r_err;
    logic [CSUM_WIDTH-1:0] r_csum;
    logic [CSUM_WIDTH-1:0] w_csum_total;

    assign w_csum_total = r_csum + IN_DATA;
`endif

    assign w_accept    = IN_VALID && r_in_ready;
    assign w_go        = w_accept && (r_state == ST_DATA);
    assign w_last_byte = (r_remaining == 16'd1);

    mem_write_strobe #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES)
    ) u_strobe (
        .clk         (CLK),
        .rst         (RST),
        .i_go        (w_go),
        .o_we_bar    (MEM_WE_bar),
        .o_phase_end (w_phase_end),
        .o_done      (w_done)
    );

    // IN_READY is registered, so every transition sets it for the state entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_addr      <= '0;
            r_data      <= 8'h00;
            r_byte_hi   <= 8'h00;
            r_remaining <= 16'h0000;
            r_drive     <= 1'b0;
            r_busy      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
            r_err       <= 1'b0;
            r_csum      <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (START) begin
                        r_state     <= ST_HDR0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cpu_rst_n <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                        r_err       <= 1'b0;
                        r_csum      <= '0;
`endif
                    end
                end
                ST_HDR0: begin
                    if (w_accept) begin
                        r_byte_hi <= IN_DATA;
                        r_state   <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (w_accept) begin
                        r_addr  <= ADDR_WIDTH'({r_byte_hi, IN_DATA});
                        r_state <= ST_HDR2;
                    end
                end
                ST_HDR2: begin
                    if (w_accept) begin
                        r_byte_hi <= IN_DATA;
                        r_state   <= ST_HDR3;
                    end
                end
                ST_HDR3: begin
                    if (w_accept) begin
                        r_remaining <= {r_byte_hi, IN_DATA};
                        if ({r_byte_hi, IN_DATA} == 16'h0000) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                            r_state    <= ST_CSUM;
                            r_in_ready <= 1'b1;
`else
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
`endif
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_data     <= IN_DATA;
                        r_drive    <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_phase_end) r_state <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (w_phase_end) r_state <= ST_HOLDW;
                end
                ST_HOLDW: begin
                    if (w_done) begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 16'd1;
                        if (w_last_byte) begin
                            r_drive <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                            r_state    <= ST_CSUM;
                            r_in_ready <= 1'b1;
`else
                            r_state    <= ST_DONE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
`endif
                        end else begin
                            r_state    <= ST_DATA;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
`ifdef MEM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        // Header + data + trailer must sum to zero modulo 256.
                        if (w_csum_total == '0) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    r_state     <= ST_RUN;
                    r_cpu_rst_n <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_in_ready <= 1'b0;
                    r_drive    <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase

`ifdef MEM_LOADER_CHECKSUM_EN
            if (w_accept && (r_state != ST_CSUM)) r_csum <= w_csum_total;
`endif
        end
    end

    assign IN_READY    = r_in_ready;
    assign MEM_ADDR    = r_addr;
    assign MEM_DATA    = r_data;
    assign MEM_DRIVE   = r_drive;
    assign CPU_RST_bar = r_cpu_rst_n;
    assign BUSY        = r_busy;

`ifdef MEM_LOADER_CHECKSUM_EN
    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ============================================================================
// Module      : tb_mem_loader
// Description : Scoreboard bench for mem_loader (honours MEM_LOADER_CHECKSUM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_loader;

    localparam int AW = 16;
    localparam int SC = 1;
    localparam int PC = 2;
    localparam int HC = 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [7:0]    IN_DATA = 8'h00;
    logic          IN_VALID = 1'b0;
    logic          IN_READY;
    logic [AW-1:0] MEM_ADDR;
    logic [7:0]    MEM_DATA;
    logic          MEM_WE_bar;
    logic          MEM_DRIVE;
    logic          CPU_RST_bar;
    logic          BUSY;
    logic          ERR;

    mem_loader #(
        .ADDR_WIDTH   (AW),
        .SETUP_CYCLES (SC),
        .PULSE_CYCLES (PC),
        .HOLD_CYCLES  (HC)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .IN_DATA     (IN_DATA),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_DATA    (MEM_DATA),
        .MEM_WE_bar  (MEM_WE_bar),
        .MEM_DRIVE   (MEM_DRIVE),
        .CPU_RST_bar (CPU_RST_bar),
        .BUSY        (BUSY),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        sb_q[$];
    logic [7:0] frame_q[$];

    int          acc_cyc = 0;
    int          n_writes = 0;
    bit          drive_seen = 1'b0;
    logic        prev_we = 1'b1;
    int          pulse_len = 0;
    logic [15:0] hold_addr = '0;
    logic [7:0]  hold_data = '0;

    // Write monitor: pops the scoreboard on every strobe fall, checks bus stability.
    always @(negedge CLK) begin
        if (RST) begin
            prev_we   <= 1'b1;
            pulse_len <= 0;
        end else begin
            if (MEM_DRIVE) drive_seen <= 1'b1;
            if (prev_we && !MEM_WE_bar) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_write", 32'(MEM_ADDR), 32'hFFFF_FFFF);
                end else begin
                    check_eq("wr_addr", 32'(MEM_ADDR), 32'(sb_q[0].addr));
                    check_eq("wr_data", 32'(MEM_DATA), 32'(sb_q[0].data));
                    void'(sb_q.pop_front());
                end
                check_eq("setup_latency", 32'(cyc - acc_cyc), 32'(SC));
                check_eq("drive_on_write", 32'(MEM_DRIVE), 32'd1);
                hold_addr <= MEM_ADDR;
                hold_data <= MEM_DATA;
                pulse_len <= 1;
                n_writes  <= n_writes + 1;
            end else if (!prev_we && !MEM_WE_bar) begin
                check_eq("addr_stable", 32'(MEM_ADDR), 32'(hold_addr));
                check_eq("data_stable", 32'(MEM_DATA), 32'(hold_data));
                pulse_len <= pulse_len + 1;
            end else if (!prev_we && MEM_WE_bar) begin
                check_eq("pulse_width", 32'(pulse_len), 32'(PC));
            end
            prev_we <= MEM_WE_bar;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        t = 0;
        if (gaps) begin
            IN_VALID = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        IN_DATA  = b;
        IN_VALID = 1'b1;
        while (!IN_READY && t < 500) begin
            @(negedge CLK);
            t++;
        end
        if (!IN_READY) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
            IN_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        @(negedge CLK);
        acc_cyc = cyc;
    endtask

    task automatic run_frame(input bit gaps, input int n_send);
        logic [15:0] base;
        int          len;
        int          n;
        base = {frame_q[0], frame_q[1]};
        len  = int'({frame_q[2], frame_q[3]});
        n    = (n_send < 0) ? frame_q.size() : n_send;
        for (int i = 0; i < n; i++) begin
            if (i >= 4 && i < 4 + len)
                sb_q.push_back(wr_t'({16'(base + 16'(i - 4)), frame_q[i]}));
            send_byte(frame_q[i], gaps && (i >= 4));
        end
        IN_VALID = 1'b0;
    endtask

    task automatic finish_frame();
`ifdef MEM_LOADER_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
        foreach (frame_q[i]) s = s + frame_q[i];
        frame_q.push_back(8'(-s));
`endif
    endtask

    task automatic start_pulse();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_busy_low(input string tag);
        int t;
        t = 0;
        while (BUSY && t < 1000) begin
            @(negedge CLK);
            t++;
        end
        check_eq({tag, "_busy_low"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;

        // Reset values
        repeat (2) @(negedge CLK);
        check_eq("rst_we_bar", 32'(MEM_WE_bar), 32'd1);
        check_eq("rst_drive", 32'(MEM_DRIVE), 32'd0);
        check_eq("rst_ready", 32'(IN_READY), 32'd0);
        check_eq("rst_cpu", 32'(CPU_RST_bar), 32'd0);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_err", 32'(ERR), 32'd0);
        check_eq("rst_addr", 32'(MEM_ADDR), 32'd0);
        check_eq("rst_data", 32'(MEM_DATA), 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check_eq("idle_ready", 32'(IN_READY), 32'd0);

        // Basic three-byte load
        frame_q = '{8'h12, 8'h34, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        finish_frame();
        n0 = n_writes;
        start_pulse();
        check_eq("t1_busy", 32'(BUSY), 32'd1);
        check_eq("t1_ready", 32'(IN_READY), 32'd1);
        run_frame(1'b0, -1);
        wait_busy_low("t1");
        check_eq("t1_cpu_held", 32'(CPU_RST_bar), 32'd0);
        check_eq("t1_drive_done", 32'(MEM_DRIVE), 32'd0);
        @(negedge CLK);
        check_eq("t1_cpu_release", 32'(CPU_RST_bar), 32'd1);
        check_eq("t1_nwrites", 32'(n_writes - n0), 32'd3);
        check_eq("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("t1_err", 32'(ERR), 32'd0);

        // Address wrap, restarted from RUN
        frame_q = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22};
        finish_frame();
        n0 = n_writes;
        start_pulse();
        check_eq("t2_cpu_held", 32'(CPU_RST_bar), 32'd0);
        check_eq("t2_busy", 32'(BUSY), 32'd1);
        run_frame(1'b0, -1);
        wait_busy_low("t2");
        @(negedge CLK);
        check_eq("t2_cpu_release", 32'(CPU_RST_bar), 32'd1);
        check_eq("t2_nwrites", 32'(n_writes - n0), 32'd2);
        check_eq("t2_err", 32'(ERR), 32'd0);

        // Zero-length frame: no strobe, no bus ownership
        frame_q = '{8'h00, 8'h10, 8'h00, 8'h00};
        finish_frame();
        n0 = n_writes;
        drive_seen = 1'b0;
        start_pulse();
        run_frame(1'b0, -1);
        wait_busy_low("t3");
        @(negedge CLK);
        check_eq("t3_cpu_release", 32'(CPU_RST_bar), 32'd1);
        check_eq("t3_nwrites", 32'(n_writes - n0), 32'd0);
        check_eq("t3_drive_seen", 32'(drive_seen), 32'd0);

        // Random IN_VALID gaps during data
        frame_q = '{8'h01, 8'h00, 8'h00, 8'h08};
        for (int i = 0; i < 8; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        finish_frame();
        n0 = n_writes;
        start_pulse();
        run_frame(1'b1, -1);
        wait_busy_low("t4");
        @(negedge CLK);
        check_eq("t4_cpu_release", 32'(CPU_RST_bar), 32'd1);
        check_eq("t4_nwrites", 32'(n_writes - n0), 32'd8);
        check_eq("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset during the second byte's pulse, then a clean reload
        frame_q = '{8'h00, 8'h20, 8'h00, 8'h03, 8'hD1, 8'hD2, 8'hD3};
        finish_frame();
        start_pulse();
        run_frame(1'b0, 6);
        n0 = 0;
        while (MEM_WE_bar && n0 < 50) begin
            @(negedge CLK);
            n0++;
        end
        check_eq("t5_in_pulse", 32'(MEM_WE_bar), 32'd0);
        #2;
        RST = 1'b1;
        #1;
        check_eq("t5_we_async", 32'(MEM_WE_bar), 32'd1);
        check_eq("t5_cpu", 32'(CPU_RST_bar), 32'd0);
        check_eq("t5_busy", 32'(BUSY), 32'd0);
        check_eq("t5_drive", 32'(MEM_DRIVE), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("t5_idle_ready", 32'(IN_READY), 32'd0);
        n0 = n_writes;
        start_pulse();
        run_frame(1'b0, -1);
        wait_busy_low("t5");
        @(negedge CLK);
        check_eq("t5_cpu_release", 32'(CPU_RST_bar), 32'd1);
        check_eq("t5_nwrites", 32'(n_writes - n0), 32'd3);

`ifdef MEM_LOADER_CHECKSUM_EN
        // Correct trailer
        frame_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'hFA};
        start_pulse();
        run_frame(1'b0, -1);
        wait_busy_low("t6");
        check_eq("t6_err", 32'(ERR), 32'd0);
        @(negedge CLK);
        check_eq("t6_cpu_release", 32'(CPU_RST_bar), 32'd1);

        // Bad trailer
        frame_q = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h05, 8'hFB};
        start_pulse();
        run_frame(1'b0, -1);
        wait_busy_low("t7");
        repeat (3) @(negedge CLK);
        check_eq("t7_err", 32'(ERR), 32'd1);
        check_eq("t7_cpu_held", 32'(CPU_RST_bar), 32'd0);
        check_eq("t7_ready", 32'(IN_READY), 32'd0);
        start_pulse();
        check_eq("t7_err_cleared", 32'(ERR), 32'd0);
`else
        check_eq("err_tied_low", 32'(ERR), 32'd0);
`endif

        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
